opb_regbank_ppc2simulink: RTL



---
 rtl/opb_regbank_ppc2simulink.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/opb_regbank_ppc2simulink.sv
// OPB slave bank of C_NUM_REGS 32-bit PPC-writable registers exported to Simulink with per-word update strobes.
// Define OPB_REGBANK_SHADOW_EN for shadowed writes committed atomically by a write to index C_NUM_REGS.
module opb_regbank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h01000400,
    parameter logic [31:0] C_HIGHADDR   = 32'h010004FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5",
    parameter int unsigned C_NUM_REGS   = 4,
    parameter logic [31:0] C_RESET_VAL  = 32'h00000000
) (
    input  logic                     OPB_Clk,
    input  logic                     OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1]  OPB_ABus,
    input  logic [0:3]               OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]  OPB_DBus,
    input  logic                     OPB_RNW,
    input  logic                     OPB_select,
    input  logic                     OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]  Sl_DBus,
    output logic                     Sl_xferAck,
    output logic                     Sl_errAck,
    output logic                     Sl_retry,
    output logic                     Sl_toutSup,
    output logic [C_NUM_REGS*32-1:0] user_data_out,
    output logic [C_NUM_REGS-1:0]    user_data_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_GAP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0]           w_addr;
    logic [31:0]           w_off;
    logic [31:0]           w_idx;
    logic [31:0]           w_wdata;
    logic [31:0]           w_rdata;
    logic [31:0]           w_mask;
    logic [3:0]            w_be;
    logic                  w_hit;
    logic                  w_take;
    logic                  w_any_be;
    logic                  w_unused;

    logic [31:0]           r_regs [C_NUM_REGS];
    logic [31:0]           r_dbus;
    logic [C_NUM_REGS-1:0] r_valid;
`ifdef OPB_REGBANK_SHADOW_EN
    logic [31:0]           r_shadow [C_NUM_REGS];
    logic [C_NUM_REGS-1:0] r_dirty;
`endif

    if (C_OPB_DWIDTH != 32 || C_NUM_REGS < 1 || C_NUM_REGS > 16 || C_FAMILY == "") begin : g_bad_cfg
        $error("opb_regbank_ppc2simulink: unsupported configuration");
    end

    // Descending vectors keep OPB bit 0 as user bit 31, so plain assignment does the bit reversal.
    assign w_addr   = OPB_ABus;
    assign w_wdata  = OPB_DBus;
    assign w_be     = OPB_BE;
    assign w_off    = w_addr - C_BASEADDR;
    assign w_idx    = {2'b00, w_off[31:2]};
    assign w_hit    = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
    assign w_take   = (r_state == S_IDLE) && w_hit;
    assign w_any_be = |w_be;
    assign w_mask   = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
    assign w_unused = ^{OPB_seqAddr, w_off[1:0]};

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_hit) w_next = S_ACK;
            S_ACK:   w_next = S_GAP;
            S_GAP:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
`ifdef OPB_REGBANK_SHADOW_EN
            if (w_idx == k) w_rdata = r_shadow[k];
`else
            if (w_idx == k) w_rdata = r_regs[k];
`endif
        end
`ifdef OPB_REGBANK_SHADOW_EN
        if (w_idx == C_NUM_REGS) w_rdata[C_NUM_REGS-1:0] = r_dirty;
`endif
    end

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_dbus  <= '0;
            r_valid <= '0;
            for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
                r_regs[k] <= C_RESET_VAL;
`ifdef OPB_REGBANK_SHADOW_EN
                r_shadow[k] <= C_RESET_VAL;
`endif
            end
`ifdef OPB_REGBANK_SHADOW_EN
            r_dirty <= '0;
`endif
        end else begin
            r_dbus  <= '0;
            r_valid <= '0;
            if (w_take && OPB_RNW) begin
                r_dbus <= w_rdata;
            end
            if (w_take && !OPB_RNW) begin
`ifdef OPB_REGBANK_SHADOW_EN
                for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
                    if (w_idx == k && w_any_be) begin
                        r_shadow[k] <= (r_shadow[k] & ~w_mask) | (w_wdata & w_mask);
                        r_dirty[k]  <= 1'b1;
                    end
                end
                // Commit publishes all dirty words on the same edge so Simulink never sees a partial update.
                if (w_idx == C_NUM_REGS) begin
                    for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
                        if (r_dirty[k]) r_regs[k] <= r_shadow[k];
                    end
                    r_valid <= r_dirty;
                    r_dirty <= '0;
                end
`else
                for (int unsigned k = 0; k < C_NUM_REGS; k++) begin
                    if (w_idx == k && w_any_be) begin
                        r_regs[k]  <= (r_regs[k] & ~w_mask) | (w_wdata & w_mask);
                        r_valid[k] <= 1'b1;
                    end
                end
`endif
            end
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign user_data_out[32*g +: 32] = r_regs[g];
    end

    assign Sl_DBus         = r_dbus;
    assign Sl_xferAck      = (r_state == S_ACK);
    assign user_data_valid = r_valid;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;

endmodule
